qddc: RTL and testbench

Quadrature digital down-converter for the receive path: the counterpart of the transmit up-converter. It takes I/Q samples from the ADC interface at the full `clk` rate and can optionally mix them to baseband with the shared `tuner` NCO/mixer. It then decimates by 256 with a 4-stage CIC and delivers 16-bit I/Q words with a one-cycle `out_valid` strobe to the downstream channel filter and FIFO.

---
 rtl/qddc.sv | 196 +++++++++++++++++++
 tb/tb_qddc.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/qddc.sv
// Quadrature down-converter: registered I/Q input, optional NCO mixer, 4-stage CIC decimating by 256.
// One output pair every 256 cycles with a single-cycle out_valid; free-running, no backpressure.
module qddc #(
    parameter int ISZ = 14,
    parameter int OSZ = 16,
    parameter int FSZ = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [ISZ-1:0] in_i,
    input  logic signed [ISZ-1:0] in_q,
    input  logic [FSZ-1:0]        lo_freq,
    input  logic                  lo_ns_en,
    input  logic                  iq_swap,
    input  logic                  tuner_byp,
    output logic signed [OSZ-1:0] out_i,
    output logic signed [OSZ-1:0] out_q,
    output logic                  out_valid
);
    localparam int N     = 4;
    localparam int DLOG2 = 8;
    localparam int W     = 16 + N * DLOG2;

    logic signed [15:0]  x      [2];
    logic signed [15:0]  mix    [2];
    logic signed [15:0]  cic_in [2];
    logic signed [W-1:0] integ  [2][N];
    logic signed [W-1:0] comb   [2][N];
    logic signed [W-1:0] dly    [2][N];
    logic [DLOG2-1:0]    dec_cnt;
    logic [N:1]          en;
    logic                dec_strobe;

    // Left-align the ADC word to 16 bits; the datapath register needs no reset.
    always_ff @(posedge clk) begin
        x[0] <= 16'(iq_swap ? in_q : in_i) << (16 - ISZ);
        x[1] <= 16'(iq_swap ? in_i : in_q) << (16 - ISZ);
    end

    tuner #(.FSZ(FSZ)) u_tuner (
        .clk   (clk),
        .reset (reset | tuner_byp),
        .in_i  (x[0]),
        .in_q  (x[1]),
        .freq  (lo_freq),
        .ns_en (lo_ns_en),
        .out_i (mix[0]),
        .out_q (mix[1])
    );

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            cic_in[c] = tuner_byp ? x[c] : mix[c];
        end
    end

    assign dec_strobe = &dec_cnt;

    // Integrators and combs wrap freely; the R^N gain fits exactly in W bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_cnt   <= '0;
            en        <= '0;
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < N; k++) begin
                    integ[c][k] <= '0;
                    comb[c][k]  <= '0;
                    dly[c][k]   <= '0;
                end
            end
        end else begin
            dec_cnt   <= dec_cnt + 1'b1;
            en        <= {en[N-1:1], dec_strobe};
            out_valid <= en[N];
            for (int c = 0; c < 2; c++) begin
                integ[c][0] <= integ[c][0] + W'(cic_in[c]);
                for (int k = 1; k < N; k++) begin
                    integ[c][k] <= integ[c][k] + integ[c][k-1];
                end
                if (dec_strobe) begin
                    comb[c][0] <= integ[c][N-1] - dly[c][0];
                    dly[c][0]  <= integ[c][N-1];
                end
                // Each comb stage fires one edge after its predecessor.
                for (int k = 1; k < N; k++) begin
                    if (en[k]) begin
                        comb[c][k] <= comb[c][k-1] - dly[c][k];
                        dly[c][k]  <= comb[c][k-1];
                    end
                end
            end
            if (en[N]) begin
                out_i <= OSZ'(comb[0][N-1] >>> (W - OSZ));
                out_q <= OSZ'(comb[1][N-1] >>> (W - OSZ));
            end
        end
    end
endmodule

// NCO and complex down-mixer: out = in * exp(-j*phase), 2-cycle latency.
// Streams every cycle; no backpressure.
module tuner #(
    parameter int FSZ = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] in_i,
    input  logic signed [15:0] in_q,
    input  logic [FSZ-1:0]     freq,
    input  logic               ns_en,
    output logic signed [15:0] out_i,
    output logic signed [15:0] out_q
);
    logic [FSZ-1:0]     phase;
    logic [FSZ-1:0]     ph_dith;
    logic [15:0]        lfsr;
    logic [5:0]         idx;
    logic [4:0]         k;
    logic [4:0]         kc;
    logic signed [15:0] cos_v, sin_v;
    logic signed [15:0] cos_r, sin_r, xi_r, xq_r;
    logic signed [32:0] acc_i, acc_q;

    function automatic logic [15:0] qsin(input logic [4:0] a);
        case (a)
            5'd0:  qsin = 16'd0;
            5'd1:  qsin = 16'd3212;
            5'd2:  qsin = 16'd6393;
            5'd3:  qsin = 16'd9512;
            5'd4:  qsin = 16'd12539;
            5'd5:  qsin = 16'd15446;
            5'd6:  qsin = 16'd18204;
            5'd7:  qsin = 16'd20787;
            5'd8:  qsin = 16'd23170;
            5'd9:  qsin = 16'd25330;
            5'd10: qsin = 16'd27245;
            5'd11: qsin = 16'd28898;
            5'd12: qsin = 16'd30273;
            5'd13: qsin = 16'd31356;
            5'd14: qsin = 16'd32137;
            5'd15: qsin = 16'd32609;
            default: qsin = 16'd32767;
        endcase
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767)       sat16 = 16'sh7fff;
        else if (v < -17'sd32768) sat16 = 16'sh8000;
        else                      sat16 = v[15:0];
    endfunction

    // Dither only touches phase bits below the table index.
    assign ph_dith = phase + (ns_en ? (FSZ'(lfsr) << (FSZ - 22)) : '0);
    assign idx     = 6'(ph_dith >> (FSZ - 6));
    assign k       = {1'b0, idx[3:0]};
    assign kc      = 5'd16 - k;

    always_comb begin
        cos_v = '0;
        sin_v = '0;
        case (idx[5:4])
            2'd0: begin cos_v =  $signed(qsin(kc)); sin_v =  $signed(qsin(k));  end
            2'd1: begin cos_v = -$signed(qsin(k));  sin_v =  $signed(qsin(kc)); end
            2'd2: begin cos_v = -$signed(qsin(kc)); sin_v = -$signed(qsin(k));  end
            default: begin cos_v = $signed(qsin(k)); sin_v = -$signed(qsin(kc)); end
        endcase
    end

    assign acc_i = 33'(xi_r) * 33'(cos_r) + 33'(xq_r) * 33'(sin_r);
    assign acc_q = 33'(xq_r) * 33'(cos_r) - 33'(xi_r) * 33'(sin_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            lfsr  <= 16'hace1;
            cos_r <= '0;
            sin_r <= '0;
            xi_r  <= '0;
            xq_r  <= '0;
            out_i <= '0;
            out_q <= '0;
        end else begin
            phase <= phase + freq;
            lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hb400 : 16'h0000);
            cos_r <= cos_v;
            sin_r <= sin_v;
            xi_r  <= in_i;
            xq_r  <= in_q;
            out_i <= sat16(17'(acc_i >>> 16));
            out_q <= sat16(17'(acc_q >>> 16));
        end
    end
endmodule

// File: tb/tb_qddc.sv
// Bench for qddc: DC vector table, randomized bypass traffic against a direct-form CIC model, mid-period reset.
module tb_qddc;
    localparam int HLEN = 4 * 255 + 1;

    logic               clk;
    logic               reset;
    logic signed [13:0] in_i, in_q;
    logic [25:0]        lo_freq;
    logic               lo_ns_en, iq_swap, tuner_byp;
    logic signed [15:0] out_i, out_q;
    logic               out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    longint h [HLEN];
    int hist_i [$];
    int hist_q [$];

    typedef struct {
        int vi; int vq; bit sw; bit byp; int lof; int ncyc; int ei; int eq; int tol;
    } vec_t;
    vec_t tbl [7];

    qddc dut (
        .clk       (clk),
        .reset     (reset),
        .in_i      (in_i),
        .in_q      (in_q),
        .lo_freq   (lo_freq),
        .lo_ns_en  (lo_ns_en),
        .iq_swap   (iq_swap),
        .tuner_byp (tuner_byp),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint tol);
        n_checks++;
        if (act > tol || act < -tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected |value| <= %0d at %0t", name, act, tol, $time);
        end
    endtask

    // Impulse response of four cascaded 256-tap boxcars.
    task automatic build_h();
        longint tmp [HLEN];
        int len = 256;
        foreach (h[i]) h[i] = (i < 256) ? 1 : 0;
        repeat (3) begin
            foreach (tmp[i]) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < 256; j++)
                    tmp[i+j] += h[i];
            h = tmp;
            len += 255;
        end
    endtask

    task automatic push_hist();
        hist_i.push_back(int'(iq_swap ? in_q : in_i) * 4);
        hist_q.push_back(int'(iq_swap ? in_i : in_q) * 4);
    endtask

    // hist[0] holds the sample driven in the last reset cycle (it still reaches the integrators).
    function automatic longint model(input int t, input bit ch);
        longint acc = 0;
        int s;
        for (int n = 0; n < HLEN; n++) begin
            s = t - 5 - n;
            if (s >= -1) acc += h[n] * longint'(ch ? hist_q[s+1] : hist_i[s+1]);
        end
        return acc >>> 32;
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            step();
            check("reset_out_i", out_i, 0);
            check("reset_out_q", out_q, 0);
            check("reset_out_valid", out_valid, 0);
        end
        reset = 1'b0;
    endtask

    task automatic run(input int ncyc, input int vi, input int vq, input bit sw, input bit byp,
                       input int lof, input bit rnd, input bit dc_chk,
                       input int ei, input int eq, input int tol);
        int  strobes = 0;
        bit  exp_v;
        int  t;
        hist_i.delete();
        hist_q.delete();
        push_hist();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            exp_v = (cyc >= 260) && ((cyc - 260) % 256 == 0);
            check("out_valid_timing", out_valid, exp_v);
            if (exp_v) begin
                strobes++;
                if (byp) begin
                    t = 255 + 256 * (strobes - 1);
                    check("model_i", out_i, model(t, 1'b0));
                    check("model_q", out_q, model(t, 1'b1));
                end
            end
            if (dc_chk && strobes >= 5) begin
                if (tol == 0) begin
                    check("steady_i", out_i, ei);
                    check("steady_q", out_q, eq);
                end else begin
                    check_tol("null_i", out_i, tol);
                    check_tol("null_q", out_q, tol);
                end
            end
            if (rnd) begin
                in_i     = ($urandom_range(0, 7) == 0) ? -14'sd8192 : 14'($urandom);
                in_q     = ($urandom_range(0, 7) == 0) ?  14'sd8191 : 14'($urandom);
                iq_swap  = 1'($urandom);
                lo_freq  = 26'($urandom);
                lo_ns_en = 1'($urandom);
            end else begin
                in_i     = 14'(vi);
                in_q     = 14'(vq);
                iq_swap  = sw;
                lo_freq  = 26'(lof);
                lo_ns_en = 1'b0;
            end
            tuner_byp = byp;
            push_hist();
            step();
        end
    endtask

    initial begin
        tbl[0] = '{vi: 0,     vq: 0,    sw: 0, byp: 1, lof: 0,       ncyc: 1600,  ei: 0,      eq: 0,     tol: 0};
        tbl[1] = '{vi: 1000,  vq: -500, sw: 0, byp: 1, lof: 0,       ncyc: 1600,  ei: 4000,   eq: -2000, tol: 0};
        tbl[2] = '{vi: 1000,  vq: -500, sw: 1, byp: 1, lof: 0,       ncyc: 1600,  ei: -2000,  eq: 4000,  tol: 0};
        tbl[3] = '{vi: -8192, vq: 8191, sw: 0, byp: 1, lof: 0,       ncyc: 20000, ei: -32768, eq: 32764, tol: 0};
        tbl[4] = '{vi: 8191,  vq: -8192, sw: 1, byp: 1, lof: 0,      ncyc: 1600,  ei: -32768, eq: 32764, tol: 0};
        tbl[5] = '{vi: 4000,  vq: 0,    sw: 0, byp: 0, lof: 1 << 24, ncyc: 2000,  ei: 0,      eq: 0,     tol: 8};
        tbl[6] = '{vi: -1,    vq: 1,    sw: 0, byp: 1, lof: 0,       ncyc: 1600,  ei: -4,     eq: 4,     tol: 0};

        build_h();
        reset = 1'b1; in_i = '0; in_q = '0; lo_freq = '0;
        lo_ns_en = 1'b0; iq_swap = 1'b0; tuner_byp = 1'b1;

        for (int i = 0; i < 7; i++) begin
            in_i = 14'(tbl[i].vi); in_q = 14'(tbl[i].vq);
            iq_swap = tbl[i].sw; tuner_byp = tbl[i].byp; lo_freq = 26'(tbl[i].lof);
            do_reset(10);
            run(tbl[i].ncyc, tbl[i].vi, tbl[i].vq, tbl[i].sw, tbl[i].byp, tbl[i].lof,
                1'b0, 1'b1, tbl[i].ei, tbl[i].eq, tbl[i].tol);
        end

        // Random bypass traffic with per-cycle swap toggling.
        in_i = '0; in_q = '0; iq_swap = 1'b0; tuner_byp = 1'b1;
        do_reset(10);
        run(2400, 0, 0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 0, 0);

        // Reset in cycle 257 aborts the comb sequence in flight.
        in_i = 14'sd1000; in_q = -14'sd500; iq_swap = 1'b0; tuner_byp = 1'b1;
        do_reset(10);
        run(257, 1000, -500, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_i", out_i, 0);
        check("midreset_out_q", out_q, 0);
        run(1600, 1000, -500, 1'b0, 1'b1, 0, 1'b0, 1'b1, 4000, -2000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
